// File: rtl/combo_sweep_checker_if.sv
// Bundle between the sweep checker and the combinational circuit under test.
// master drives mode select and operands, slave returns the responses.
interface combo_sweep_checker_if;
    logic [1:0] userinput;
    logic [3:0] drv_d;
    logic       drv_i;
    logic [1:0] drv_a;
    logic [2:0] drv_abc;
    logic [7:0] res_y;
    logic [1:0] res_s;
    logic [3:0] res_dec;
    logic       res_x;
    logic       res_sum;
    logic       res_carry;

    modport master (
        output userinput, drv_d, drv_i, drv_a, drv_abc,
        input  res_y, res_s, res_dec, res_x, res_sum, res_carry
    );

    modport slave (
        input  userinput, drv_d, drv_i, drv_a, drv_abc,
        output res_y, res_s, res_dec, res_x, res_sum, res_carry
    );
endinterface

// File: rtl/combo_sweep_checker.sv
// Sweeps every operand vector of the selected mode through the circuit,
// checks the settled response against a golden model, reports the outcome.
module combo_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic [3:0] err_count,
    output logic [2:0] first_fail,
    output logic       bad_mode,
    output logic       pass,
    combo_sweep_checker_if.master cif
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    state_t     state, state_n;
    logic [1:0] mode_q, mode_n;
    logic [2:0] step, step_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] err_n;
    logic [2:0] ff_n;
    logic       bad_n, pass_n;
    logic       mism, last;
    logic [3:0] oh4;
    logic [7:0] oh8;
    logic       maj;

    assign oh4  = 4'b0001 << step[1:0];
    assign oh8  = 8'b0000_0001 << step;
    assign maj  = (step[0] & step[1]) | (step[0] & step[2]) | (step[1] & step[2]);
    assign last = (mode_q == 2'b01) ? (step == 3'd3) : (step == 3'd7);
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        cif.userinput = 2'b11;
        cif.drv_d     = 4'b0;
        cif.drv_i     = 1'b0;
        cif.drv_a     = 2'b0;
        cif.drv_abc   = 3'b0;
        if (state == DRIVE || state == CHECK) begin
            cif.userinput = mode_q;
            unique case (mode_q)
                2'b00: begin
                    cif.drv_d = oh4;
                    cif.drv_i = step[2];
                end
                2'b01: cif.drv_a = {step[0], step[1]};
                2'b10: cif.drv_abc = step;
                default: ;
            endcase
        end
    end

    // Only the outputs meaningful in each mode are compared.
    always_comb begin
        mism = 1'b0;
        unique case (mode_q)
            2'b00: mism = (cif.res_s != step[1:0]) ||
                          (cif.res_y[3:0] != (step[2] ? oh4 : 4'b0));
            2'b01: mism = (cif.res_dec != oh4) || !cif.res_x;
            2'b10: mism = (cif.res_y != oh8) ||
                          (cif.res_sum != ^step) ||
                          (cif.res_carry != maj);
            default: mism = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        step_n  = step;
        cnt_n   = cnt;
        err_n   = err_count;
        ff_n    = first_fail;
        bad_n   = bad_mode;
        pass_n  = pass;
        unique case (state)
            IDLE: begin
                if (start) begin
                    mode_n = mode;
                    err_n  = 4'd0;
                    ff_n   = 3'd0;
                    pass_n = 1'b0;
                    step_n = 3'd0;
                    cnt_n  = 4'd0;
                    bad_n  = (mode == 2'b11);
                    state_n = (mode == 2'b11) ? DONE : DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == 4'(SETTLE_CYCLES - 1)) begin
                    cnt_n   = 4'd0;
                    state_n = CHECK;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            CHECK: begin
                if (mism) begin
                    if (err_count != 4'd15) err_n = err_count + 4'd1;
                    if (err_count == 4'd0) ff_n = step;
                end
                if (last) begin
                    state_n = DONE;
                    pass_n  = (err_n == 4'd0) && !bad_mode;
                end else begin
                    step_n  = step + 3'd1;
                    state_n = DRIVE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= 2'b00;
            step       <= 3'd0;
            cnt        <= 4'd0;
            err_count  <= 4'd0;
            first_fail <= 3'd0;
            bad_mode   <= 1'b0;
            pass       <= 1'b0;
        end else begin
            state      <= state_n;
            mode_q     <= mode_n;
            step       <= step_n;
            cnt        <= cnt_n;
            err_count  <= err_n;
            first_fail <= ff_n;
            bad_mode   <= bad_n;
            pass       <= pass_n;
        end
    end
endmodule

// File: tb/tb_combo_sweep_checker.sv
// Bench for combo_sweep_checker: behavioural circuit responder with fault
// knobs, queued expected vectors and results compared as the DUT produces them.
module tb_combo_sweep_checker;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [1:0] mode;
    logic       busy, done, bad_mode, pass;
    logic [3:0] err_count;
    logic [2:0] first_fail;
    logic       carry_stuck, x_stuck, noise;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic [3:0] err;
        logic [2:0] ff;
        logic       bad;
        logic       pas;
    } res_t;

    logic [11:0] exp_q[$];
    res_t        res_q[$];

    combo_sweep_checker_if cif();

    combo_sweep_checker #(.SETTLE_CYCLES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .err_count  (err_count),
        .first_fail (first_fail),
        .bad_mode   (bad_mode),
        .pass       (pass),
        .cif        (cif)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [1:0] s;
        s = 2'b0;
        cif.res_y     = 8'b0;
        cif.res_s     = 2'b0;
        cif.res_dec   = 4'b0;
        cif.res_x     = 1'b0;
        cif.res_sum   = 1'b0;
        cif.res_carry = 1'b0;
        case (cif.userinput)
            2'b00: begin
                for (int b = 0; b < 4; b++)
                    if (cif.drv_d[b]) s = 2'(b);
                cif.res_s = s;
                cif.res_y[3:0] = cif.drv_i ? (4'b0001 << s) : 4'b0;
                if (noise) cif.res_y[7:4] = 4'hF;
            end
            2'b01: begin
                cif.res_dec = 4'b0001 << {cif.drv_a[0], cif.drv_a[1]};
                cif.res_x = !x_stuck;
                if (noise) cif.res_y = 8'hFF;
            end
            2'b10: begin
                cif.res_y = 8'b1 << cif.drv_abc;
                cif.res_sum = ^cif.drv_abc;
                cif.res_carry = carry_stuck ? 1'b0 :
                    (cif.drv_abc[0] & cif.drv_abc[1]) |
                    (cif.drv_abc[0] & cif.drv_abc[2]) |
                    (cif.drv_abc[1] & cif.drv_abc[2]);
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] vec(input logic [1:0] m, input int k);
        logic [3:0] d;
        logic       i;
        logic [1:0] a;
        logic [2:0] abc, kk;
        kk = 3'(k);
        d = 4'b0; i = 1'b0; a = 2'b0; abc = 3'b0;
        case (m)
            2'b00: begin d = 4'b0001 << kk[1:0]; i = kk[2]; end
            2'b01: a = {kk[0], kk[1]};
            2'b10: abc = kk;
            default: ;
        endcase
        return {m, d, i, a, abc};
    endfunction

    function automatic logic [11:0] obs();
        return {cif.userinput, cif.drv_d, cif.drv_i, cif.drv_a, cif.drv_abc};
    endfunction

    task automatic sweep(input logic [1:0] m, input logic [3:0] e,
                         input logic [2:0] f, input logic b, input logic p,
                         input logic mid_start);
        int   n, cyc;
        res_t r;
        n = (m == 2'b01) ? 4 : (m == 2'b11) ? 0 : 8;
        @(negedge clk);
        for (int k = 0; k < n; k++)
            for (int c = 0; c < 2; c++) exp_q.push_back(vec(m, k));
        res_q.push_back('{err: e, ff: f, bad: b, pas: p});
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 64) begin
            if (exp_q.size() > 0) check("vec", 32'(obs()), 32'(exp_q.pop_front()));
            check("busy", 32'(busy), 1);
            if (mid_start && cyc == 5) begin
                start = 1'b1;
                mode  = 2'b01;
            end else begin
                start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        exp_q.delete();
        r = res_q.pop_front();
        check("latency", 32'(cyc), 32'(n * 2));
        check("done", 32'(done), 1);
        check("done_vec", 32'(obs()), 32'h C00);
        check("err", 32'(err_count), 32'(r.err));
        check("ff", 32'(first_fail), 32'(r.ff));
        check("bad", 32'(bad_mode), 32'(r.bad));
        check("pass", 32'(pass), 32'(r.pas));
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        check("busy_end", 32'(busy), 0);
        check("idle_vec", 32'(obs()), 32'h C00);
        check("err_hold", 32'(err_count), 32'(r.err));
        check("pass_hold", 32'(pass), 32'(r.pas));
    endtask

    initial begin
        logic saw_done;
        rst = 1'b1; start = 1'b1; mode = 2'b10;
        carry_stuck = 1'b0; x_stuck = 1'b0; noise = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_vec", 32'(obs()), 32'h C00);
        check("rst_err", 32'(err_count), 0);
        check("rst_ff", 32'(first_fail), 0);
        check("rst_bad", 32'(bad_mode), 0);
        check("rst_pass", 32'(pass), 0);
        start = 1'b0;
        rst = 1'b0;

        sweep(2'b10, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        carry_stuck = 1'b1;
        sweep(2'b10, 4'd4, 3'd3, 1'b0, 1'b0, 1'b0);
        carry_stuck = 1'b0;
        noise = 1'b1;
        sweep(2'b00, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        noise = 1'b0;
        x_stuck = 1'b1;
        sweep(2'b01, 4'd4, 3'd0, 1'b0, 1'b0, 1'b0);
        x_stuck = 1'b0;
        sweep(2'b11, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        sweep(2'b10, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1);

        x_stuck = 1'b1;
        @(negedge clk);
        start = 1'b1; mode = 2'b01;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_err", 32'(err_count), 3);
        check("mid_vec", 32'(obs()), 32'(vec(2'b01, 3)));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_vec", 32'(obs()), 32'h C00);
        check("rst_mid_err", 32'(err_count), 0);
        saw_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("rst_no_done", 32'(saw_done), 0);
        x_stuck = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
